// File: rtl/recon_serializer.sv
// recon_serializer
//   Output stage of the decoder datapath. Captures one frame (nine signed
//   Q4.16 sigmoid outputs plus the original nine-bit pixel vector) through a
//   valid/ready handshake and streams the reconstruction one pixel per
//   accepted beat: a thresholded bit together with its probability value.
//   After the last beat the Hamming distance between the reconstruction and
//   the original pixels is presented with a one-cycle err_valid pulse.
//
//   Optional feature macro: RECON_CLAMP_EN
//     defined     - out_prob is saturated to [0, 1.0] (20'sh00000..20'sh10000)
//     not defined - out_prob is the captured sigmoid word, unmodified
//   out_pixel and err_count always use the raw captured value.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   frame available on x_in / sig_in
//   in_ready   out  block can accept a frame (IDLE only)
//   x_in       in   [N_PIX-1:0] original pixels, bit i = pixel i
//   sig_in     in   [N_PIX*DATA_W-1:0] sigmoid words, pixel i at [DATA_W*i +: DATA_W]
//   out_valid  out  beat valid (STREAM only)
//   out_ready  in   downstream accepts beat
//   out_pixel  out  reconstructed bit of the current pixel
//   out_prob   out  [DATA_W-1:0] probability of the current pixel, signed Q4.16
//   out_idx    out  [3:0] current pixel index
//   out_last   out  high on the beat with the final index
//   err_valid  out  one-cycle pulse, err_count is final
//   err_count  out  [3:0] mismatches between reconstruction and x_in

module recon_serializer #(
    parameter int                 DATA_W = 20,
    parameter int                 N_PIX  = 9,
    parameter logic signed [19:0] THRESH = 20'sh08000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_PIX-1:0]          x_in,
    input  logic [N_PIX*DATA_W-1:0]   sig_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_pixel,
    output logic [DATA_W-1:0]         out_prob,
    output logic [3:0]                out_idx,
    output logic                      out_last,
    output logic                      err_valid,
    output logic [3:0]                err_count
);

    localparam logic [3:0]               LAST_IDX = 4'(N_PIX - 1);
    localparam logic signed [DATA_W-1:0] ONE      = DATA_W'(20'sh10000);
    localparam logic signed [DATA_W-1:0] ZERO     = '0;

    typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_t;

    state_t                     state;
    logic [N_PIX-1:0]           x_r;
    logic signed [DATA_W-1:0]   sig_r [N_PIX];
    logic [3:0]                 nxt_idx;

    // Binarization: signed compare, so negative words always give 0.
    function automatic logic is_one(input logic signed [DATA_W-1:0] v);
        return v >= DATA_W'(THRESH);
    endfunction

    // Probability presented downstream; optionally saturated to [0, 1.0].
    function automatic logic signed [DATA_W-1:0] prob_out(input logic signed [DATA_W-1:0] v);
`ifdef RECON_CLAMP_EN
        if (v < ZERO)
            return ZERO;
        if (v > ONE)
            return ONE;
        return v;
`else
        return v;
`endif
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == STREAM);
    assign err_valid = (state == REPORT);
    assign nxt_idx   = out_idx + 4'd1;

    // Frame capture: data registers carry no reset, they are only read
    // while STREAM is active, which always follows a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            x_r <= x_in;
            for (int i = 0; i < N_PIX; i++)
                sig_r[i] <= $signed(sig_in[i*DATA_W +: DATA_W]);
        end
    end

    // Control FSM with registered beat outputs. The next beat is loaded in
    // the same edge that accepts the current one, so out_* never depend
    // combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_pixel <= 1'b0;
            out_prob  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= STREAM;
                        out_idx   <= '0;
                        out_pixel <= is_one($signed(sig_in[DATA_W-1:0]));
                        out_prob  <= prob_out($signed(sig_in[DATA_W-1:0]));
                        out_last  <= (LAST_IDX == 4'd0);
                        err_count <= '0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_pixel != x_r[out_idx])
                            err_count <= err_count + 4'd1;
                        if (out_idx == LAST_IDX) begin
                            state    <= REPORT;
                            out_last <= 1'b0;
                        end else begin
                            out_idx   <= nxt_idx;
                            out_pixel <= is_one(sig_r[nxt_idx]);
                            out_prob  <= prob_out(sig_r[nxt_idx]);
                            out_last  <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recon_serializer.sv
// Bench for recon_serializer: randomized frames checked against a
// behavioural model computed from the binarization / clamp rules.
module tb_recon_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [8:0]   x_in;
    logic [179:0] sig_in;
    logic         out_valid;
    logic         out_ready;
    logic         out_pixel;
    logic [19:0]  out_prob;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         err_valid;
    logic [3:0]   err_count;

    recon_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .sig_in    (sig_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_prob  (out_prob),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err_valid (err_valid),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  fx;
    logic [19:0] fsig [9];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: pixel = (value >= 0.5), prob optionally clamped to [0, 1.0]
    function automatic logic m_pix(input logic [19:0] w);
        int v;
        v = $signed(w);
        return v >= 32768;
    endfunction

    function automatic logic [19:0] m_prob(input logic [19:0] w);
        int v;
        v = $signed(w);
`ifdef RECON_CLAMP_EN
        if (v < 0)
            v = 0;
        else if (v > 65536)
            v = 65536;
`endif
        return v[19:0];
    endfunction

    function automatic logic [19:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 20'($urandom);
            1:       return 20'(32768 + $urandom_range(0, 4) - 2);
            2:       return 20'($urandom_range(0, 65536));
            default: return 20'(-int'($urandom_range(1, 300000)));
        endcase
    endfunction

    task automatic rand_frame;
        fx = 9'($urandom);
        for (int i = 0; i < 9; i++)
            fsig[i] = rand_word();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_out_valid"}, out_valid, 0);
        check_eq({pfx, "_out_pixel"}, out_pixel, 0);
        check_eq({pfx, "_out_prob"},  out_prob,  0);
        check_eq({pfx, "_out_idx"},   out_idx,   0);
        check_eq({pfx, "_out_last"},  out_last,  0);
        check_eq({pfx, "_err_valid"}, err_valid, 0);
        check_eq({pfx, "_err_count"}, err_count, 0);
        check_eq({pfx, "_in_ready"},  in_ready,  1);
    endtask

    // mode: 0 = out_ready always 1, 1 = toggles starting at 0, 2 = random
    // exp_cyc: expected err_valid cycle after capture (0 = not checked)
    // garbage: keep in_valid high with changing inputs during the frame
    // abort_idx: assert rst while this beat is presented (-1 = never)
    task automatic run_frame(input int mode, input int exp_cyc, input bit garbage, input int abort_idx);
        int k, cnt, n, exp_err;
        bit done, rdy;
        exp_err = 0;
        for (int i = 0; i < 9; i++)
            if (m_pix(fsig[i]) != fx[i])
                exp_err++;

        n = 0;
        while (!in_ready && n < 100) begin
            tick;
            n++;
        end
        check_eq("in_ready_idle", in_ready, 1);
        x_in = fx;
        for (int i = 0; i < 9; i++)
            sig_in[i*20 +: 20] = fsig[i];
        in_valid = 1'b1;
        tick;
        if (!garbage)
            in_valid = 1'b0;

        k = 0;
        cnt = 1;
        done = 1'b0;
        while (!done && cnt < 200) begin
            if (garbage) begin
                x_in = 9'($urandom);
                for (int i = 0; i < 9; i++)
                    sig_in[i*20 +: 20] = 20'($urandom);
            end
            check_eq("in_ready_busy", in_ready, 0);
            if (k < 9) begin
                if (k == abort_idx) begin
                    rst = 1'b1;
                    #1;
                    check_reset_outputs("abort");
                    tick;
                    tick;
                    rst = 1'b0;
                    out_ready = 1'b1;
                    for (int c = 0; c < 12; c++) begin
                        check_eq("abort_no_err_valid", err_valid, 0);
                        check_eq("abort_no_out_valid", out_valid, 0);
                        tick;
                    end
                    return;
                end
                check_eq("out_valid", out_valid, 1);
                check_eq("out_idx",   out_idx,   k);
                check_eq("out_pixel", out_pixel, m_pix(fsig[k]));
                check_eq("out_prob",  out_prob,  m_prob(fsig[k]));
                check_eq("out_last",  out_last,  (k == 8));
                check_eq("err_valid_early", err_valid, 0);
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cnt % 2 == 0);
                    default: rdy = 1'($urandom);
                endcase
                out_ready = rdy;
                if (rdy)
                    k++;
            end else begin
                check_eq("err_valid", err_valid, 1);
                check_eq("err_count", err_count, exp_err);
                check_eq("out_valid_report", out_valid, 0);
                if (exp_cyc > 0)
                    check_eq("err_valid_cycle", cnt, exp_cyc);
                done = 1'b1;
            end
            tick;
            cnt++;
        end
        check_eq("frame_done", done, 1);
        check_eq("in_ready_after",  in_ready,  1);
        check_eq("err_valid_pulse", err_valid, 0);
        check_eq("err_count_hold",  err_count, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x_in = '0;
        sig_in = '0;
        tick;
        tick;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick;
        check_eq("post_reset_in_ready",  in_ready,  1);
        check_eq("post_reset_out_valid", out_valid, 0);

        // All ones, all 0.75: no errors, full-rate timing
        fx = 9'h1FF;
        for (int i = 0; i < 9; i++)
            fsig[i] = 20'h0C000;
        run_frame(0, 10, 1'b0, -1);

        // Threshold boundaries against an all-zero original
        fx = 9'h000;
        for (int i = 0; i < 9; i++)
            case (i % 4)
                0: fsig[i] = 20'h08000;
                1: fsig[i] = 20'h07FFF;
                2: fsig[i] = 20'hFFFFF;
                default: fsig[i] = 20'h10000;
            endcase
        run_frame(0, 10, 1'b0, -1);

        // Back-pressure: out_ready toggles 0/1
        rand_frame();
        run_frame(1, 19, 1'b0, -1);

        // in_valid held high with changing inputs during the frame
        rand_frame();
        run_frame(0, 10, 1'b1, -1);
        rand_frame();
        run_frame(0, 10, 1'b0, -1);

        // Reset mid-frame at beat 4, then a fresh frame
        rand_frame();
        run_frame(0, 0, 1'b0, 4);
        rand_frame();
        run_frame(0, 10, 1'b0, -1);

        // Out-of-range probabilities
        rand_frame();
        fsig[1] = 20'h1A000;
        fsig[5] = 20'hFF000;
        fsig[6] = 20'h10000;
        fsig[7] = 20'h00000;
        run_frame(2, 0, 1'b0, -1);

        for (int f = 0; f < 6; f++) begin
            rand_frame();
            run_frame(2, 0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recon_serializer.md
# recon_serializer

Output stage of the decoder datapath. Captures the nine sigmoid outputs and the nine-bit input pixel vector of one frame through a valid/ready handshake. Streams each reconstructed pixel serially, one per accepted beat, as a thresholded bit plus its probability value. After the last beat it reports the Hamming distance between the reconstruction and the original input.

## Interface
Parameters:
- `DATA_W`, 20: width of one sigmoid value, signed Q4.16 (1.0 = 20'sh10000).
- `N_PIX`, 9: pixels per frame.
- `THRESH`, 20'sh08000: binarization threshold (0.5).

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: frame available on `x_in`/`sig_in`.
- `in_ready` output 1: block can accept a frame.
- `x_in` input 9: original input pixels, bit i = pixel i.
- `sig_in` input 180: sigmoid outputs, pixel i at bits [20i+19:20i], signed.
- `out_valid` output 1: `out_*` beat valid.
- `out_ready` input 1: downstream accepts beat.
- `out_pixel` output 1: reconstructed bit for current pixel.
- `out_prob` output 20: probability of current pixel, signed Q4.16.
- `out_idx` output 4: current pixel index, 0..8.
- `out_last` output 1: high on beat with `out_idx`==8.
- `err_valid` output 1: one-cycle pulse, `err_count` final.
- `err_count` output 4: mismatches between `out_pixel` and `x_in` for the frame, 0..9.

## Operation
- FSM states are IDLE, STREAM and REPORT.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&&`in_ready`: register `x_in` and all nine `sig_in` words, clear `err_count` and the index, then go to STREAM.
- STREAM:
  - `out_valid`=1 and `out_idx`=index.
  - `out_pixel` = (sig[index] >= `THRESH`), signed compare. Negative values give 0; exactly `THRESH` gives 1.
  - On `out_valid`&&`out_ready`: `err_count` increments if `out_pixel` != x[index].
  - If the index is 8, go to REPORT; otherwise increment the index.
- REPORT: `err_valid`=1 for exactly one cycle, then return to IDLE. `err_count` holds its value until the next capture.
- `in_ready`=0 in STREAM and REPORT. Frames are not queued; `in_valid` is ignored outside IDLE.
- While `out_valid`=1 and `out_ready`=0, all `out_*` outputs stay stable and the index does not advance.
- Captured data is independent of later changes on `x_in`/`sig_in`.
- Widths: the index is 4 bits and never exceeds 8. `err_count` saturates at 9 by construction; no wrap is possible.

## Timing
- Reset values: state IDLE, `in_ready`=1 after reset release. `out_valid`, `out_pixel`, `out_prob`, `out_idx`, `out_last`, `err_valid` and `err_count` are all 0.
- Capture edge at cycle T gives the first beat (`out_idx`=0) with `out_valid`=1 at T+1.
- With `out_ready` held high, one beat is accepted per cycle. The last beat is accepted at T+9, `err_valid` pulses at T+10, and `in_ready`=1 at T+11.
- Minimum frame period is 11 cycles.
- `err_count` is updated in the same edge as the accepting handshake. Its final value is visible no later than the `err_valid` cycle.
- Reset asserted mid-frame aborts the frame immediately. All outputs go to their reset values, no `err_valid` pulse is produced, and the partial frame is discarded.
- `out_*` outputs are registered; there is no combinational path from `out_ready` to `out_*`. `in_ready` and `out_valid` are derived from state only.

## Configuration
- `RECON_CLAMP_EN` defined: `out_prob` is saturated to [20'sh00000, 20'sh10000]. Values below 0 are output as 0; values above 1.0 are output as 1.0.
- `RECON_CLAMP_EN` not defined: `out_prob` is the captured sigmoid word, unmodified.
- In both cases `out_pixel` and `err_count` use the raw captured value.

## Test plan
- Reset, then frame `x_in`=9'h1FF with all `sig_in`=20'sh0C000 and `out_ready`=1:
  - nine beats with `out_pixel`=1 and `out_idx` 0..8;
  - `out_last` high only on idx 8;
  - `err_valid` pulse with `err_count`=0 at capture+10.
- Frame `x_in`=9'h000 with sig = {8000, 7FFF, FFFFF(-1), 10000, …} alternating:
  - 20'sh08000 gives 1, 20'sh07FFF gives 0, negative gives 0;
  - `err_count` equals the number of ones, checked against the model (e.g. 5).
- Back-pressure: `out_ready` toggles 1/0 every cycle.
  - `out_*` stay stable while stalled.
  - Exactly nine accepted beats are seen, in order.
  - The frame completes at capture+19.
- `in_valid` held high throughout STREAM with changing `x_in`/`sig_in`:
  - `in_ready`=0;
  - streamed data matches the first captured frame;
  - the next frame is accepted only after `err_valid`.
- `rst` asserted during beat idx 4:
  - all outputs are 0 in the same cycle;
  - no `err_valid` pulse;
  - a fresh frame afterwards streams from idx 0 with `err_count` from 0.
- With `RECON_CLAMP_EN` defined, sig=20'sh1A000 and 20'shFF000:
  - `out_prob` = 20'sh10000 and 20'sh00000;
  - without the macro, the raw values are output.
